adc_acq_sequencer: RTL and testbench

Per-channel acquisition sequencer that drives the select/update strobes of the ADC data mux for one fill. On a trigger it emits, in order: one fill header, then for each waveform a waveform header, its ADC data words and an optional idle gap, then a checksum word. It also generates the DDR3 write-FIFO write enable, aligned to the mux's one-cycle output register, and keeps the fill number and current waveform number.

---
 rtl/adc_acq_sequencer.sv | 158 +++++++++++++++
 tb/tb_adc_acq_sequencer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/adc_acq_sequencer.sv
// Acquisition sequencer for one ADC channel: walks fill header, waveform headers,
// data words, gaps and checksum, driving the mux selects and the aligned FIFO write strobe.
module adc_acq_sequencer #(
  parameter int WFM_W  = 12,
  parameter int LEN_W  = 23,
  parameter int GAP_W  = 22,
  parameter int FILL_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trigger,
  input  logic [WFM_W-1:0]  num_waveforms,
  input  logic [LEN_W-1:0]  waveform_len,
  input  logic [GAP_W-1:0]  waveform_gap,
  input  logic              adc_dat_valid,
  input  logic              fifo_full,
  output logic              select_fill_hdr,
  output logic              select_waveform_hdr,
  output logic              select_dat,
  output logic              select_checksum,
  output logic              checksum_update,
  output logic [WFM_W-1:0]  current_waveform_num,
  output logic [FILL_W-1:0] fill_num,
  output logic              fifo_wr_en,
  output logic              busy,
  output logic              fill_done,
  output logic              trigger_dropped,
  output logic              overflow_err
);

  localparam logic [WFM_W-1:0]  WFM_ONE  = 1;
  localparam logic [LEN_W-1:0]  LEN_ONE  = 1;
  localparam logic [GAP_W-1:0]  GAP_ONE  = 1;
  localparam logic [FILL_W-1:0] FILL_ONE = 1;

  typedef enum logic [2:0] {
    IDLE, FILL_HDR, WFM_HDR, DATA, GAP, CHKSUM, DONE
  } state_t;

  state_t            state_reg, state_next;
  logic [WFM_W-1:0]  num_wfm_reg;
  logic [WFM_W-1:0]  wfm_num_reg, wfm_num_next;
  logic [LEN_W-1:0]  len_reg;
  logic [LEN_W-1:0]  word_cnt_reg, word_cnt_next;
  logic [GAP_W-1:0]  gap_reg;
  logic [GAP_W-1:0]  gap_cnt_reg, gap_cnt_next;
  logic [FILL_W-1:0] fill_num_reg, fill_num_next;
  logic              fifo_wr_en_reg;
  logic              trigger_dropped_reg;
  logic              overflow_err_reg;
  logic              end_wfm;

  always_comb begin
    state_next          = state_reg;
    wfm_num_next        = wfm_num_reg;
    word_cnt_next       = word_cnt_reg;
    gap_cnt_next        = gap_cnt_reg;
    fill_num_next       = fill_num_reg;
    end_wfm             = 1'b0;
    select_fill_hdr     = 1'b0;
    select_waveform_hdr = 1'b0;
    select_dat          = 1'b0;
    select_checksum     = 1'b0;
    checksum_update     = 1'b0;
    fill_done           = 1'b0;

    case (state_reg)
      IDLE: begin
        if (trigger) begin
          wfm_num_next = '0;
          state_next   = FILL_HDR;
        end
      end
      FILL_HDR: begin
        select_fill_hdr = 1'b1;
        state_next      = WFM_HDR;
      end
      WFM_HDR: begin
        select_waveform_hdr = 1'b1;
        word_cnt_next       = '0;
        if (len_reg != '0) state_next = DATA;
        else               end_wfm    = 1'b1;
      end
      DATA: begin
        // The mux consumes a word only when the ADC presents a fresh one.
        select_dat      = adc_dat_valid;
        checksum_update = adc_dat_valid;
        if (adc_dat_valid) begin
          word_cnt_next = word_cnt_reg + LEN_ONE;
          if (word_cnt_reg == len_reg - LEN_ONE) end_wfm = 1'b1;
        end
      end
      GAP: begin
        gap_cnt_next = gap_cnt_reg + GAP_ONE;
        if (gap_cnt_reg == gap_reg - GAP_ONE) state_next = WFM_HDR;
      end
      CHKSUM: begin
        select_checksum = 1'b1;
        state_next      = DONE;
      end
      DONE: begin
        fill_done     = 1'b1;
        fill_num_next = fill_num_reg + FILL_ONE;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (end_wfm) begin
      if (wfm_num_reg == num_wfm_reg - WFM_ONE) begin
        state_next = CHKSUM;
      end else begin
        wfm_num_next = wfm_num_reg + WFM_ONE;
        gap_cnt_next = '0;
        state_next   = (gap_reg != '0) ? GAP : WFM_HDR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg           <= IDLE;
      num_wfm_reg         <= '0;
      wfm_num_reg         <= '0;
      len_reg             <= '0;
      word_cnt_reg        <= '0;
      gap_reg             <= '0;
      gap_cnt_reg         <= '0;
      fill_num_reg        <= '0;
      fifo_wr_en_reg      <= 1'b0;
      trigger_dropped_reg <= 1'b0;
      overflow_err_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wfm_num_reg  <= wfm_num_next;
      word_cnt_reg <= word_cnt_next;
      gap_cnt_reg  <= gap_cnt_next;
      fill_num_reg <= fill_num_next;
      if (state_reg == IDLE && trigger) begin
        num_wfm_reg <= (num_waveforms == '0) ? WFM_ONE : num_waveforms;
        len_reg     <= waveform_len;
        gap_reg     <= waveform_gap;
      end
      // Delayed one cycle to line up with the mux output register.
      fifo_wr_en_reg      <= select_fill_hdr | select_waveform_hdr | select_dat | select_checksum;
      trigger_dropped_reg <= trigger && (state_reg != IDLE);
      if (fifo_wr_en_reg && fifo_full) overflow_err_reg <= 1'b1;
    end
  end

  assign current_waveform_num = wfm_num_reg;
  assign fill_num             = fill_num_reg;
  assign fifo_wr_en           = fifo_wr_en_reg;
  assign busy                 = (state_reg != IDLE);
  assign trigger_dropped      = trigger_dropped_reg;
  assign overflow_err         = overflow_err_reg;

endmodule

// File: tb/tb_adc_acq_sequencer.sv
// Bench for adc_acq_sequencer: directed and randomized fills compared cycle by cycle
// against an expected schedule built from the fill layout rules.
module tb_adc_acq_sequencer;
  localparam int WFM_W = 12;
  localparam int LEN_W = 23;
  localparam int GAP_W = 22;
  localparam int FW    = 5;   // narrow fill counter so the wrap is reached quickly
  localparam int C_NONE = 0, C_FILL = 1, C_WHDR = 2, C_DAT = 3, C_CHK = 4, C_DONE = 5;

  logic              clk = 1'b0;
  logic              rst_n, trigger, adc_dat_valid, fifo_full;
  logic [WFM_W-1:0]  num_waveforms;
  logic [LEN_W-1:0]  waveform_len;
  logic [GAP_W-1:0]  waveform_gap;
  logic              select_fill_hdr, select_waveform_hdr, select_dat, select_checksum;
  logic              checksum_update, fifo_wr_en, busy, fill_done, trigger_dropped, overflow_err;
  logic [WFM_W-1:0]  current_waveform_num;
  logic [FW-1:0]     fill_num;

  adc_acq_sequencer #(.WFM_W(WFM_W), .LEN_W(LEN_W), .GAP_W(GAP_W), .FILL_W(FW)) dut (
    .clk(clk), .rst_n(rst_n), .trigger(trigger), .num_waveforms(num_waveforms),
    .waveform_len(waveform_len), .waveform_gap(waveform_gap), .adc_dat_valid(adc_dat_valid),
    .fifo_full(fifo_full), .select_fill_hdr(select_fill_hdr),
    .select_waveform_hdr(select_waveform_hdr), .select_dat(select_dat),
    .select_checksum(select_checksum), .checksum_update(checksum_update),
    .current_waveform_num(current_waveform_num), .fill_num(fill_num), .fifo_wr_en(fifo_wr_en),
    .busy(busy), .fill_done(fill_done), .trigger_dropped(trigger_dropped),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int fill_model = 0;
  bit ovf_model  = 1'b0;
  int code [0:1023];
  int wn   [0:1023];
  bit v    [0:1023];
  bit full [0:1023];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sel"}, 32'({select_fill_hdr, select_waveform_hdr, select_dat, select_checksum}), 0);
    check({tag, "_upd"}, 32'(checksum_update), 0);
    check({tag, "_wr"}, 32'(fifo_wr_en), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(fill_done), 0);
    check({tag, "_drop"}, 32'(trigger_dropped), 0);
    check({tag, "_fillnum"}, 32'(fill_num), 0);
    check({tag, "_wnum"}, 32'(current_waveform_num), 0);
    check({tag, "_ovf"}, 32'(overflow_err), 0);
  endtask

  // Expected schedule: cycle 0 is the trigger cycle; drop_c/full_c/rst_c < 0 disable.
  task automatic run_fill(input string name, input int wq, input int lq, input int gq,
                          input int vmode, input int drop_c, input int full_c, input int rst_c);
    int weff, k, cnt, last, nwr, nupd, exp_fill;
    bit prev_wr;
    weff = (wq == 0) ? 1 : wq;
    for (int i = 0; i < 1024; i++) begin
      code[i] = C_NONE;
      wn[i]   = 0;
      case (vmode)
        0:       v[i] = 1'b1;
        1:       v[i] = i[0];
        default: v[i] = (i >= 400) || ($urandom_range(9) < 7);
      endcase
      full[i] = (i == full_c);
    end
    code[1] = C_FILL;
    k = 2;
    for (int w = 0; w < weff; w++) begin
      code[k] = C_WHDR; wn[k] = w; k++;
      cnt = 0;
      while (cnt < lq) begin
        if (v[k]) begin code[k] = C_DAT; cnt++; end
        k++;
      end
      if (w < weff - 1) k += gq;
    end
    code[k] = C_CHK; k++;
    code[k] = C_DONE; last = k;
    if (drop_c > last) drop_c = last;

    prev_wr = 1'b0; nwr = 0; nupd = 0;
    for (int c = 0; c <= last + 1; c++) begin
      @(posedge clk); #1;
      trigger       = (c == 0) || (c == drop_c);
      adc_dat_valid = v[c];
      fifo_full     = full[c];
      rst_n         = !(c == rst_c);
      if (c == 0) begin
        num_waveforms = WFM_W'(wq); waveform_len = LEN_W'(lq); waveform_gap = GAP_W'(gq);
      end else begin
        num_waveforms = WFM_W'($urandom); waveform_len = LEN_W'($urandom);
        waveform_gap = GAP_W'($urandom);
      end
      @(negedge clk);
      if (rst_c >= 0 && c == rst_c + 1) begin
        check_all_zero({name, "_rst"});
        fill_model = 0; ovf_model = 1'b0; trigger = 1'b0;
        return;
      end
      check({name, "_sel"}, 32'({select_fill_hdr, select_waveform_hdr, select_dat, select_checksum}),
            32'({code[c] == C_FILL, code[c] == C_WHDR, code[c] == C_DAT, code[c] == C_CHK}));
      check({name, "_upd"}, 32'(checksum_update), 32'(code[c] == C_DAT));
      check({name, "_wr"}, 32'(fifo_wr_en), 32'(prev_wr));
      check({name, "_busy"}, 32'(busy), 32'(c >= 1 && c <= last));
      check({name, "_done"}, 32'(fill_done), 32'(c == last));
      check({name, "_drop"}, 32'(trigger_dropped), 32'(drop_c >= 1 && c == drop_c + 1));
      check({name, "_ovf"}, 32'(overflow_err), 32'(ovf_model));
      exp_fill = (c <= last) ? fill_model : (fill_model + 1) % (1 << FW);
      check({name, "_fillnum"}, 32'(fill_num), 32'(exp_fill));
      if (code[c] == C_WHDR) check({name, "_wnum"}, 32'(current_waveform_num), 32'(wn[c]));
      nwr  += int'(fifo_wr_en);
      nupd += int'(checksum_update);
      if (prev_wr && full[c]) ovf_model = 1'b1;
      prev_wr = (code[c] >= C_FILL) && (code[c] <= C_CHK);
    end
    trigger = 1'b0;
    fill_model = (fill_model + 1) % (1 << FW);
    check({name, "_wnum_end"}, 32'(current_waveform_num), 32'(weff - 1));
    check({name, "_nwr"}, 32'(nwr), 32'(2 + weff * (1 + lq)));
    check({name, "_nupd"}, 32'(nupd), 32'(weff * lq));
    $display("fill %s W=%0d L=%0d G=%0d cycles=%0d writes=%0d", name, wq, lq, gq, last + 1, nwr);
  endtask

  initial begin
    rst_n = 1'b0; trigger = 1'b0; adc_dat_valid = 1'b0; fifo_full = 1'b0;
    num_waveforms = '0; waveform_len = '0; waveform_gap = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("reset");

    run_fill("w2l3g4",   2, 3, 4, 0, -1, -1, -1);
    run_fill("w1l4alt",  1, 4, 0, 1, -1, -1, -1);
    run_fill("w0l0g0",   0, 0, 0, 0, -1, -1, -1);
    run_fill("w3l1g0",   3, 1, 0, 0, -1, -1, -1);
    run_fill("drop5",    2, 3, 4, 0,  5, -1, -1);
    run_fill("dropdone", 1, 1, 0, 0, 99, -1, -1);
    run_fill("ovf3",     2, 3, 1, 0, -1,  4, -1);

    // Random fills push the narrow fill counter through its wrap.
    for (int n = 0; n < 30; n++) begin
      run_fill("rand", $urandom_range(4), $urandom_range(5), $urandom_range(3), 2,
               ($urandom_range(1) == 1) ? $urandom_range(12, 1) : -1,
               ($urandom_range(9) == 0) ? $urandom_range(8, 2) : -1, -1);
    end

    run_fill("rstdata", 2, 3, 4, 0, -1, -1, 4);
    run_fill("afterrst", 1, 2, 0, 2, -1, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
